add_arbiter: RTL
================

# add_arbiter

Round-robin arbiter and sequencer sharing one 32-bit carry-lookahead adder among up to N_REQ requesters. Each requester presents an operand pair plus carry-in over a valid/ready handshake. The block grants one requester per cycle, computes a+b+cin on the shared adder, and returns the registered sum, carry-out and requester ID over a single response channel with backpressure. It sits between the ALU issue logic and the adder datapath.

## Interface
- N_REQ, default 4: number of requesters, 2..8
- W, default 32: operand width; the shared adder is fixed at 32
- IDW, default $clog2(N_REQ): requester ID width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  N_REQ*W  operand A, requester i at [i*W +: W]
- req_b  in  N_REQ*W  operand B, same packing
- req_cin  in  N_REQ  carry-in per requester
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of requester that produced the result
- rsp_sum  out  W  (a+b+cin) mod 2^W
- rsp_cout  out  1  bit W of a+b+cin

## Operation
- A single response slot holds the result; states are EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready. This is the only condition that allows a new grant.
- Arbitration is combinational from req_valid and the round-robin pointer ptr. The winner is the first i with req_valid[i] set, searching from ptr upward and wrapping.
- req_ready[winner] = can_accept & |req_valid. All other req_ready bits are 0. req_ready never asserts for a requester whose req_valid is 0.
- On accept (edge where req_valid[i] & req_ready[i]):
  - The slot loads sum, cout and id=i. rsp_valid becomes 1.
  - ptr becomes (i+1) mod N_REQ.
- If rsp_valid & rsp_ready and there is no new accept, rsp_valid becomes 0. The sum, cout and id fields hold their last values.
- If a drain and a new accept happen in the same cycle, the slot is overwritten and rsp_valid stays 1. This gives full throughput.
- When no request is accepted, ptr does not change.
- Requesters hold req_valid, req_a, req_b and req_cin stable until ready. The block never samples operands from a requester that is not granted.
- While rsp_valid & !rsp_ready, every req_ready bit is 0 and rsp_* outputs stay stable.
- Arithmetic: sum/cout = {cout,sum} = a + b + cin at full W+1 width. Wrap-around is mod 2^W. cout=1 on unsigned overflow.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, ptr=0.
  - req_ready is 0 while rst_n=0.
- Latency: accept at edge k, so rsp_valid=1 with the result after edge k. One cycle.
- Throughput: one operation per cycle while rsp_ready=1.
- req_ready is combinational from req_valid, rsp_valid and rsp_ready. There is no combinational path from req_a or req_b to any output.
- If reset asserts mid-operation, the pending result is discarded, no response is produced, and ptr returns to 0.
- Fairness: with all requesters continuously valid and rsp_ready=1, each requester is granted exactly once in every N_REQ consecutive grants.

## Structure
- Shared package add_pkg holds the W=32 constant and the response struct {id, sum, cout}.
- Sub-module rr_arbiter(N_REQ): inputs req, ptr and enable; outputs one-hot grant and encoded index. It contains no state.
- The shared adder instance computes sum and cout. The registered slot, ptr and handshake logic stay in add_arbiter.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1. Then req_ready=0, rsp_valid=0 and rsp_sum=0. After release, the first grant goes to requester 0.
- Single op: req 2 sends a=0xFFFF_FFFF, b=0x0000_0001, cin=0. Then next cycle rsp_valid=1, id=2, sum=0x0000_0000, cout=1.
- Carry-in: req 1 sends a=0x7FFF_FFFF, b=0, cin=1. Then sum=0x8000_0000, cout=0. Repeat with a=0x0000_FFFF, b=0x0000_0000, cin=1, which gives sum=0x0001_0000.
- Round-robin: all four valid, rsp_ready=1 for 8 cycles. The grant order is 0,1,2,3,0,1,2,3 and there is one response per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with the slot full. All req_ready=0, rsp_* stay stable and ptr does not change. When rsp_ready=1, a drain and a new accept happen in the same cycle.
- Mid-operation reset: pulse rst_n low while rsp_valid=1 and rsp_ready=0. Then rsp_valid=0 immediately (asynchronously), and after release the grant restarts at requester 0.

Source files
------------

// File: rtl/add_pkg.sv
// Constants and the response-slot payload shared by the adder arbiter.
package add_pkg;

    localparam int unsigned ADD_W   = 32;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned RSP_IDW = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [RSP_IDW-1:0] id;
        logic [ADD_W-1:0]   sum;
        logic               cout;
    } rsp_t;

endpackage

// File: rtl/add_cla32.sv
// 32-bit adder built from 4-bit generate/propagate groups with group-level lookahead.
module add_cla32
    import add_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int unsigned GRP  = 4;
    localparam int unsigned NGRP = ADD_W / GRP;

    always_comb begin
        logic [ADD_W-1:0] g;
        logic [ADD_W-1:0] p;
        logic [NGRP-1:0]  gg;
        logic [NGRP-1:0]  gp;
        logic [NGRP:0]    gc;
        logic             c;
        g   = a & b;
        p   = a ^ b;
        gg  = '0;
        gp  = '1;
        gc  = '0;
        c   = 1'b0;
        sum = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            for (int unsigned k = 0; k < GRP; k++) begin
                gg[j] = g[GRP*j+k] | (p[GRP*j+k] & gg[j]);
                gp[j] = gp[j] & p[GRP*j+k];
            end
        end
        gc[0] = cin;
        for (int unsigned j = 0; j < NGRP; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        // in-group carries start from the lookahead group carry
        for (int unsigned j = 0; j < NGRP; j++) begin
            c = gc[j];
            for (int unsigned k = 0; k < GRP; k++) begin
                sum[GRP*j+k] = p[GRP*j+k] ^ c;
                c = g[GRP*j+k] | (p[GRP*j+k] & c);
            end
        end
        cout = gc[NGRP];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx
);

    always_comb begin
        int unsigned pos;
        logic [IDW-1:0] sel;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            sel = IDW'(pos);
            if (!found && req[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
        // index is still reported when disabled; only the grant is gated
        if (found && enable) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sharing of one 32-bit adder among N_REQ requesters, single registered response slot.
module add_arbiter
    import add_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = ADD_W,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout
);

    slot_state_e      state;
    rsp_t             slot;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   win_idx;
    logic [N_REQ-1:0] grant;
    logic             can_accept;
    logic             accept;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic             cin_sel;
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;
    logic [ADD_W:0]   add_full;

    assign can_accept = (state == SLOT_EMPTY) | rsp_ready;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (can_accept & rst_n),
        .grant  (grant),
        .idx    (win_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // operand mux follows the winner so ungranted operands never reach the slot
    always_comb begin
        a_sel   = req_a[32'(win_idx)*W +: W];
        b_sel   = req_b[32'(win_idx)*W +: W];
        cin_sel = req_cin[win_idx];
    end

    add_cla32 u_add (
        .a    (ADD_W'(a_sel)),
        .b    (ADD_W'(b_sel)),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_full = {add_cout, add_sum};
    assign next_ptr = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            slot  <= '0;
            ptr   <= '0;
        end else if (accept) begin
            state     <= SLOT_FULL;
            slot.id   <= RSP_IDW'(win_idx);
            slot.sum  <= ADD_W'(add_full[W-1:0]);
            slot.cout <= add_full[W];
            ptr       <= next_ptr;
        end else if (state == SLOT_FULL && rsp_ready) begin
            state <= SLOT_EMPTY;
        end
    end

    assign rsp_valid = (state == SLOT_FULL);
    assign rsp_id    = IDW'(slot.id);
    assign rsp_sum   = W'(slot.sum);
    assign rsp_cout  = slot.cout;

endmodule
